// File: rtl/user_btn_debounce.sv
// User push-button conditioner.
//
// The raw pad is normalised to pressed=1, synchronised into sys_clk, and then
// debounced by a stable-count filter. A three-state FSM (idle / held / long)
// turns the clean level into single-cycle events.
//
// Ports:
//   sys_clk      in   system clock, all logic on the rising edge
//   sys_rst      in   synchronous active-high reset
//   user_btn     in   raw asynchronous button pad
//   btn_level    out  debounced level, 1 = pressed
//   press        out  one-cycle pulse on debounced press
//   btn_release  out  one-cycle pulse on debounced release ('release' is a
//                     reserved word, hence the prefix)
//   short_click  out  one-cycle pulse on a release before long_press fired
//   long_press   out  one-cycle pulse when a hold reaches LONG_CYCLES
module user_btn_debounce #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1250000,
  parameter int unsigned LONG_CYCLES     = 125000000,
  parameter int unsigned ACTIVE_HIGH     = 1
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic user_btn,
  output logic btn_level,
  output logic press,
  output logic btn_release,
  output logic short_click,
  output logic long_press
);

  localparam int unsigned DbW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HoldW = $clog2(LONG_CYCLES + 1);

  localparam logic [DbW-1:0]   DbLast   = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(LONG_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StHeld,
    StLong
  } state_e;

  // ---------------------------------------------------------------------------
  // Polarity normalisation and synchroniser
  // ---------------------------------------------------------------------------
  logic                   pad_pressed;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sample;

  assign pad_pressed = (ACTIVE_HIGH != 0) ? user_btn : ~user_btn;
  assign sample      = sync_q[SYNC_STAGES-1];

  // Reset value 0 is the released level after normalisation.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pad_pressed};
    end
  end

  // ---------------------------------------------------------------------------
  // Stable-count filter
  // ---------------------------------------------------------------------------
  logic [DbW-1:0] db_cnt_q, db_cnt_d;
  logic           level_q, level_d;
  logic           toggle;
  logic           rise;
  logic           fall;

  // Any sample matching the current level restarts the count, so only an
  // uninterrupted run of DEBOUNCE_CYCLES differing samples flips the level.
  always_comb begin
    db_cnt_d = db_cnt_q;
    level_d  = level_q;
    toggle   = 1'b0;
    if (sample == level_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DbLast) begin
      toggle   = 1'b1;
      level_d  = ~level_q;
      db_cnt_d = '0;
    end else begin
      db_cnt_d = db_cnt_q + DbW'(1);
    end
  end

  assign rise = toggle & ~level_q;
  assign fall = toggle & level_q;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      db_cnt_q <= '0;
      level_q  <= 1'b0;
    end else begin
      db_cnt_q <= db_cnt_d;
      level_q  <= level_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Event FSM
  // ---------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             short_q, short_d;
  logic             long_q, long_d;

  // State register; event outputs are registered so they line up with the
  // btn_level edge.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= StIdle;
      hold_cnt_q <= '0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      short_q    <= 1'b0;
      long_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      press_q    <= press_d;
      release_q  <= release_d;
      short_q    <= short_d;
      long_q     <= long_d;
    end
  end

  // Next state. A fall takes priority over the hold terminal count; the
  // counter stops at HoldLast so it never wraps.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (rise) begin
          state_d    = StHeld;
          hold_cnt_d = '0;
        end
      end
      StHeld: begin
        if (fall) begin
          state_d    = StIdle;
          hold_cnt_d = '0;
        end else if (hold_cnt_q == HoldLast) begin
          state_d = StLong;
        end else begin
          hold_cnt_d = hold_cnt_q + HoldW'(1);
        end
      end
      StLong: begin
        if (fall) begin
          state_d    = StIdle;
          hold_cnt_d = '0;
        end
      end
      default: begin
        state_d    = StIdle;
        hold_cnt_d = '0;
      end
    endcase
  end

  // Event outputs, computed with the same priorities as the next state.
  always_comb begin
    press_d   = 1'b0;
    release_d = 1'b0;
    short_d   = 1'b0;
    long_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        press_d = rise;
      end
      StHeld: begin
        if (fall) begin
          release_d = 1'b1;
          short_d   = 1'b1;
        end else if (hold_cnt_q == HoldLast) begin
          long_d = 1'b1;
        end
      end
      StLong: begin
        release_d = fall;
      end
      default: begin
        press_d = 1'b0;
      end
    endcase
  end

  assign btn_level   = level_q;
  assign press       = press_q;
  assign btn_release = release_q;
  assign short_click = short_q;
  assign long_press  = long_q;

endmodule

// File: tb/tb_user_btn_debounce.sv
// Bench for user_btn_debounce: one active-high and one active-low instance
// driven with the same logical button, compared every cycle against a
// window-based reference model, plus directed timing checks.
module tb_user_btn_debounce;

  localparam int unsigned S = 2;
  localparam int unsigned D = 4;
  localparam int unsigned L = 16;

  logic sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic sys_rst = 1'b1;
  logic btn_h   = 1'b0;
  logic btn_l   = 1'b1;

  logic lvl_h, press_h, rel_h, short_h, long_h;
  logic lvl_l, press_l, rel_l, short_l, long_l;

  user_btn_debounce #(
    .SYNC_STAGES    (S),
    .DEBOUNCE_CYCLES(D),
    .LONG_CYCLES    (L),
    .ACTIVE_HIGH    (1)
  ) u_dut_hi (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .user_btn   (btn_h),
    .btn_level  (lvl_h),
    .press      (press_h),
    .btn_release(rel_h),
    .short_click(short_h),
    .long_press (long_h)
  );

  user_btn_debounce #(
    .SYNC_STAGES    (S),
    .DEBOUNCE_CYCLES(D),
    .LONG_CYCLES    (L),
    .ACTIVE_HIGH    (0)
  ) u_dut_lo (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .user_btn   (btn_l),
    .btn_level  (lvl_l),
    .press      (press_l),
    .btn_release(rel_l),
    .short_click(short_l),
    .long_press (long_l)
  );

  // Bit order: {level, press, release, short, long}
  logic [4:0] obs [2];
  assign obs[0] = {lvl_h, press_h, rel_h, short_h, long_h};
  assign obs[1] = {lvl_l, press_l, rel_l, short_l, long_l};

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model. pad_hist[k] is the pressed value sampled k edges ago
  // (zeros stand in for anything before reset). The filter sees the pad S
  // edges late, so the level flips when the D samples pad_hist[S..S+D-1]
  // all disagree with the current level.
  // ---------------------------------------------------------------------------
  bit pad_hist[$];
  bit m_level;
  bit m_long_done;
  int m_n;
  int m_press_edge;
  bit e_press, e_rel, e_short, e_long;

  task automatic model_reset();
    pad_hist.delete();
    for (int k = 0; k < int'(S + D); k++) pad_hist.push_back(1'b0);
    m_level     = 1'b0;
    m_long_done = 1'b0;
  endtask

  task automatic model_edge(input bit pressed, input bit rst);
    bit flip;
    e_press = 1'b0;
    e_rel   = 1'b0;
    e_short = 1'b0;
    e_long  = 1'b0;
    m_n++;
    if (rst) begin
      model_reset();
    end else begin
      pad_hist.push_front(pressed);
      void'(pad_hist.pop_back());
      flip = 1'b1;
      for (int k = int'(S); k < int'(S + D); k++) begin
        if (pad_hist[k] == m_level) flip = 1'b0;
      end
      if (flip && !m_level) begin
        m_level      = 1'b1;
        e_press      = 1'b1;
        m_press_edge = m_n;
        m_long_done  = 1'b0;
      end else if (flip && m_level) begin
        m_level = 1'b0;
        e_rel   = 1'b1;
        e_short = !m_long_done;
      end else if (m_level && !m_long_done && m_n == m_press_edge + int'(L)) begin
        e_long      = 1'b1;
        m_long_done = 1'b1;
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed-measurement bookkeeping, relative to the last mark()
  // ---------------------------------------------------------------------------
  int mark_n;
  int press_at [2];
  int rel_at   [2];
  int long_at  [2];
  int press_n  [2];
  int rel_n    [2];
  int short_n  [2];
  int long_n   [2];

  task automatic mark();
    mark_n = 0;
    for (int i = 0; i < 2; i++) begin
      press_at[i] = -1;
      rel_at[i]   = -1;
      long_at[i]  = -1;
      press_n[i]  = 0;
      rel_n[i]    = 0;
      short_n[i]  = 0;
      long_n[i]   = 0;
    end
  endtask

  string nm [5] = '{"long", "short", "release", "press", "level"};

  task automatic step(input bit pressed, input bit rst);
    logic [4:0] exp;
    btn_h   = pressed;
    btn_l   = ~pressed;
    sys_rst = rst;
    @(posedge sys_clk);
    model_edge(pressed, rst);
    #1;
    mark_n++;
    exp = {m_level, e_press, e_rel, e_short, e_long};
    for (int i = 0; i < 2; i++) begin
      for (int b = 0; b < 5; b++) begin
        check($sformatf("%s_%s", (i == 0) ? "hi" : "lo", nm[b]), int'(obs[i][b]), int'(exp[b]));
      end
      if (obs[i][3]) begin
        press_n[i]++;
        if (press_at[i] < 0) press_at[i] = mark_n;
      end
      if (obs[i][2]) begin
        rel_n[i]++;
        if (rel_at[i] < 0) rel_at[i] = mark_n;
      end
      if (obs[i][1]) short_n[i]++;
      if (obs[i][0]) begin
        long_n[i]++;
        if (long_at[i] < 0) long_at[i] = mark_n;
      end
    end
  endtask

  task automatic run(input bit pressed, input int n);
    for (int c = 0; c < n; c++) step(pressed, 1'b0);
  endtask

  initial begin
    bit lvl;
    int len;
    m_n          = 0;
    m_press_edge = -1000;
    model_reset();
    mark();

    // 1: reset held with the button down, then press after the filter latency
    for (int c = 0; c < 3; c++) step(1'b1, 1'b1);
    mark();
    run(1'b1, 10);
    check("s1_press_edge_hi", press_at[0], 6);
    check("s1_press_edge_lo", press_at[1], 6);
    run(1'b0, 12);

    // 2: 12-cycle press gives a short click
    mark();
    run(1'b1, 12);
    run(1'b0, 12);
    for (int i = 0; i < 2; i++) begin
      check("s2_press_edge", press_at[i], 6);
      check("s2_release_edge", rel_at[i], 18);
      check("s2_short_count", short_n[i], 1);
      check("s2_long_count", long_n[i], 0);
    end

    // 3: too short to be accepted
    mark();
    run(1'b1, 3);
    run(1'b0, 10);
    for (int i = 0; i < 2; i++) check("s3_press_count", press_n[i], 0);

    // 4: bounce, then steady high starting on edge 5
    mark();
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    run(1'b1, 10);
    run(1'b0, 10);
    for (int i = 0; i < 2; i++) begin
      check("s4_press_count", press_n[i], 1);
      check("s4_press_edge", press_at[i], 10);
    end

    // 5: long hold
    mark();
    run(1'b1, 40);
    run(1'b0, 10);
    for (int i = 0; i < 2; i++) begin
      check("s5_press_edge", press_at[i], 6);
      check("s5_long_edge", long_at[i], 22);
      check("s5_long_count", long_n[i], 1);
      check("s5_release_edge", rel_at[i], 46);
      check("s5_short_count", short_n[i], 0);
    end

    // 6: reset while in the long-hold state with the pad still down; the reset
    // edge is edge 1 here, so the fresh press lands 6 edges after it
    run(1'b1, 30);
    mark();
    step(1'b1, 1'b1);
    run(1'b1, 10);
    for (int i = 0; i < 2; i++) begin
      check("s6_release_count", rel_n[i], 0);
      check("s6_press_edge", press_at[i], 7);
    end
    run(1'b0, 12);

    // Random runs of mixed length with occasional resets
    for (int r = 0; r < 150; r++) begin
      lvl = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) len = $urandom_range(1, D + 1);
      else len = $urandom_range(1, 40);
      if ($urandom_range(0, 29) == 0) step(lvl, 1'b1);
      run(lvl, len);
    end
    run(1'b0, 12);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
